// File: rtl/pp_pipeline_pkg.sv
// Shared types and defaults for the pre-processing pipeline blocks.
package pp_pipeline_pkg;

   localparam int PP_DATA_W = 24;
   localparam int PP_DIM_W  = 11;

   localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
   localparam logic [1:0] ST_DIM_ENC    = 2'd1;
   localparam logic [1:0] ST_STREAM_ENC = 2'd2;
   localparam logic [1:0] ST_DONE_ENC   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = ST_IDLE_ENC,
      ST_DIM    = ST_DIM_ENC,
      ST_STREAM = ST_STREAM_ENC,
      ST_DONE   = ST_DONE_ENC
   } wr_state_t;

   typedef struct packed {
      logic [PP_DATA_W-1:0] tdata;
      logic                 tuser;
      logic                 tlast;
   } axis_beat_t;

endpackage

// File: rtl/pp_dim_axis_writer_if.sv
// Control, dimension-FIFO, pixel-FIFO and AXI4-Stream signals of the dim/axis writer.
interface pp_dim_axis_writer_if
   import pp_pipeline_pkg::*;
#(
   parameter int DATA_W = PP_DATA_W,
   parameter int DIM_W  = PP_DIM_W
) ();

   logic              ap_start;
   logic              ap_done;
   logic              ap_continue;
   logic              ap_idle;
   logic              ap_ready;
   logic [DIM_W-1:0]  rows_dout;
   logic              rows_empty_n;
   logic              rows_read;
   logic [DIM_W-1:0]  cols_dout;
   logic              cols_empty_n;
   logic              cols_read;
   logic [DATA_W-1:0] img_dout;
   logic              img_empty_n;
   logic              img_read;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tuser;
   logic              m_axis_tlast;

   modport master (
      input  ap_start, ap_continue,
      input  rows_dout, rows_empty_n, cols_dout, cols_empty_n,
      input  img_dout, img_empty_n, m_axis_tready,
      output ap_done, ap_idle, ap_ready,
      output rows_read, cols_read, img_read,
      output m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
   );

   modport slave (
      output ap_start, ap_continue,
      output rows_dout, rows_empty_n, cols_dout, cols_empty_n,
      output img_dout, img_empty_n, m_axis_tready,
      input  ap_done, ap_idle, ap_ready,
      input  rows_read, cols_read, img_read,
      input  m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
   );

endinterface

// File: rtl/pp_axis_out_reg.sv
// Single-entry AXI4-Stream output register; a new beat may load whenever the
// held one is absent or being accepted, giving one beat per cycle at full rate.
module pp_axis_out_reg
   import pp_pipeline_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_load,
   input  axis_beat_t i_beat,
   input  logic       i_tready,
   output logic       o_tvalid,
   output axis_beat_t o_beat,
   output logic       o_canLoad,
   output logic       o_accept
);

   logic       r_valid;
   axis_beat_t r_beat;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_beat  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_beat  <= i_beat;
      end else if (i_tready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_tvalid  = r_valid;
   assign o_beat    = r_beat;
   assign o_canLoad = !r_valid | i_tready;
   assign o_accept  = r_valid & i_tready;

endmodule

// File: rtl/pp_dim_axis_writer.sv
// Tail of the pre-processing pipeline: pops one rows/cols pair per frame and
// streams rows*cols pixels from the pixel FIFO as an AXI4-Stream video frame.
module pp_dim_axis_writer
   import pp_pipeline_pkg::*;
#(
   parameter int DATA_W = PP_DATA_W,
   parameter int DIM_W  = PP_DIM_W
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst_n,
   pp_dim_axis_writer_if.master bus
);

   wr_state_t         r_state;
   wr_state_t         w_nextState;
   logic [DIM_W-1:0]  r_rows;
   logic [DIM_W-1:0]  r_cols;
   logic [DIM_W-1:0]  r_rowCnt;
   logic [DIM_W-1:0]  r_colCnt;
   logic              r_remaining;
   logic              r_apDoneReg;
   logic [DATA_W-1:0] w_pixel;
   logic              w_dimFire;
   logic              w_zeroDim;
   logic              w_lastCol;
   logic              w_lastPix;
   logic              w_canLoad;
   logic              w_load;
   logic              w_accept;
   logic              w_finalAccept;
   logic              w_tvalid;
   axis_beat_t        w_inBeat;
   axis_beat_t        w_outBeat;

   assign w_pixel   = bus.img_dout;
   assign w_dimFire = (r_state == ST_DIM) & bus.rows_empty_n & bus.cols_empty_n & ap_rst_n;
   assign w_zeroDim = (bus.rows_dout == '0) | (bus.cols_dout == '0);
   assign w_lastCol = (r_colCnt == r_cols - DIM_W'(1));
   assign w_lastPix = w_lastCol & (r_rowCnt == r_rows - DIM_W'(1));
   assign w_load    = (r_state == ST_STREAM) & w_canLoad & bus.img_empty_n & r_remaining & ap_rst_n;
   // With the last pixel already loaded, any beat accepted now is the frame's final one.
   assign w_finalAccept = (r_state == ST_STREAM) & w_accept & !r_remaining;

   assign w_inBeat.tdata = w_pixel;
   assign w_inBeat.tuser = (r_rowCnt == '0) & (r_colCnt == '0);
   assign w_inBeat.tlast = w_lastCol;

   pp_axis_out_reg u_outReg (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .i_load    (w_load),
      .i_beat    (w_inBeat),
      .i_tready  (bus.m_axis_tready),
      .o_tvalid  (w_tvalid),
      .o_beat    (w_outBeat),
      .o_canLoad (w_canLoad),
      .o_accept  (w_accept)
   );

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:   if (bus.ap_start) w_nextState = ST_DIM;
         ST_DIM:    if (w_dimFire) w_nextState = w_zeroDim ? ST_DONE : ST_STREAM;
         ST_STREAM: if (w_finalAccept) w_nextState = ST_DONE;
         ST_DONE:   if (bus.ap_continue) w_nextState = bus.ap_start ? ST_DIM : ST_IDLE;
         default:   w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_state     <= ST_IDLE;
         r_rows      <= '0;
         r_cols      <= '0;
         r_rowCnt    <= '0;
         r_colCnt    <= '0;
         r_remaining <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_dimFire) begin
            r_rows      <= bus.rows_dout;
            r_cols      <= bus.cols_dout;
            r_rowCnt    <= '0;
            r_colCnt    <= '0;
            r_remaining <= !w_zeroDim;
         end else if (w_load) begin
            if (w_lastCol) begin
               r_colCnt <= '0;
               r_rowCnt <= r_rowCnt + DIM_W'(1);
            end else begin
               r_colCnt <= r_colCnt + DIM_W'(1);
            end
            if (w_lastPix) r_remaining <= 1'b0;
         end
      end
   end

   // Done is raised combinationally on entry; the register keeps it up until acknowledged.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_apDoneReg <= 1'b0;
      end else if (bus.ap_continue) begin
         r_apDoneReg <= 1'b0;
      end else if (r_state == ST_DONE) begin
         r_apDoneReg <= 1'b1;
      end
   end

   assign bus.ap_done       = ap_rst_n & ((r_state == ST_DONE) | r_apDoneReg);
   assign bus.ap_idle       = ap_rst_n & (r_state == ST_IDLE) & !bus.ap_start;
   assign bus.ap_ready      = w_dimFire;
   assign bus.rows_read     = w_dimFire;
   assign bus.cols_read     = w_dimFire;
   assign bus.img_read      = w_load;
   assign bus.m_axis_tvalid = w_tvalid;
   assign bus.m_axis_tdata  = w_outBeat.tdata;
   assign bus.m_axis_tuser  = w_outBeat.tuser;
   assign bus.m_axis_tlast  = w_outBeat.tlast;

endmodule

// File: tb/tb_pp_dim_axis_writer.sv
// Bench for pp_dim_axis_writer: FIFO models feed frames, a scoreboard built from
// the frame rules checks every accepted beat plus handshake counts and timing.
module tb_pp_dim_axis_writer;

   localparam int DATA_W = 24;
   localparam int DIM_W  = 11;
   localparam int BUDGET = 3000;

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic              u;
      logic              l;
   } expBeat_t;

   typedef struct {
      string name;
      int    rows;
      int    cols;
      int    mode;
      int    gap;
      int    expBeats;
   } vec_t;

   logic clk;
   logic rstN;

   pp_dim_axis_writer_if #(.DATA_W(DATA_W), .DIM_W(DIM_W)) bus ();

   pp_dim_axis_writer #(.DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
      .ap_clk   (clk),
      .ap_rst_n (rstN),
      .bus      (bus)
   );

   logic [DIM_W-1:0]  rowsQ[$];
   logic [DIM_W-1:0]  colsQ[$];
   logic [DATA_W-1:0] imgQ[$];
   expBeat_t          expQ[$];

   int total = 0;
   int bad = 0;
   int cycleNo = 0;
   int rowsReadCount = 0, colsReadCount = 0, splitCount = 0, imgReadCount = 0;
   int readyCount = 0, doneCount = 0, acceptCount = 0;
   int lastReadyCycle = 0, lastDoneCycle = 0, lastAcceptCycle = 0;
   int readyMode = 0;
   int gapPct = 0;
   bit colsHold = 1'b0;
   bit popRows = 1'b0, popCols = 1'b0, popImg = 1'b0;
   bit holdPending = 1'b0;
   logic [DATA_W+1:0] heldBeat;
   logic [DATA_W-1:0] pixSeed;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycleNo);
      end
   endtask

   // Behavioural frame model: raster order, SOF on the first pixel, EOL at each row end.
   task automatic pushFrame(input int rows, input int cols);
      rowsQ.push_back(DIM_W'(rows));
      colsQ.push_back(DIM_W'(cols));
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < cols; c++) begin
            imgQ.push_back(pixSeed);
            expQ.push_back('{d: pixSeed, u: (r == 0 && c == 0), l: (c == cols - 1)});
            pixSeed = pixSeed + 1'b1;
         end
      end
   endtask

   task automatic waitReady(input int target);
      for (int k = 0; k < BUDGET && readyCount < target; k++) begin
         @(posedge clk); #1;
      end
      if (readyCount < target) checkOutput("readyTimeout", 32'(readyCount), 32'(target));
   endtask

   task automatic waitDone(input int target);
      for (int k = 0; k < BUDGET && doneCount < target; k++) begin
         @(posedge clk); #1;
      end
      if (doneCount < target) checkOutput("doneTimeout", 32'(doneCount), 32'(target));
   endtask

   task automatic applyStimulus(input int rows, input int cols);
      int r0, d0;
      r0 = readyCount;
      d0 = doneCount;
      pushFrame(rows, cols);
      bus.ap_start = 1'b1;
      waitReady(r0 + 1);
      bus.ap_start = 1'b0;
      waitDone(d0 + 1);
      @(posedge clk); #1;
   endtask

   // Monitor: sampled mid-cycle, scoring handshakes that complete at the next rising edge.
   always @(negedge clk) begin
      cycleNo++;
      if (rstN) begin
         if (bus.rows_read) rowsReadCount++;
         if (bus.cols_read) colsReadCount++;
         if (bus.rows_read != bus.cols_read) splitCount++;
         if (bus.img_read) imgReadCount++;
         if (bus.ap_ready) begin readyCount++; lastReadyCycle = cycleNo; end
         if (bus.ap_done) begin doneCount++; lastDoneCycle = cycleNo; end
         if (holdPending)
            checkOutput("holdStable",
                        32'({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast}),
                        32'({1'b1, heldBeat}));
         holdPending = bus.m_axis_tvalid && !bus.m_axis_tready;
         heldBeat = {bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast};
         if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            acceptCount++;
            lastAcceptCycle = cycleNo;
            if (expQ.size() == 0) checkOutput("extraBeat", 32'd1, 32'd0);
            else checkOutput("beat", 32'({bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast}),
                             32'(expQ.pop_front()));
         end
      end else begin
         holdPending = 1'b0;
      end
      popRows = rstN && bus.rows_read;
      popCols = rstN && bus.cols_read;
      popImg  = rstN && bus.img_read;
   end

   // FIFO and sink models, updated just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (popRows && rowsQ.size() > 0) void'(rowsQ.pop_front());
      if (popCols && colsQ.size() > 0) void'(colsQ.pop_front());
      if (popImg && imgQ.size() > 0) void'(imgQ.pop_front());
      bus.rows_empty_n = (rowsQ.size() > 0);
      bus.rows_dout    = (rowsQ.size() > 0) ? rowsQ[0] : '0;
      bus.cols_empty_n = (colsQ.size() > 0) && !colsHold;
      bus.cols_dout    = (colsQ.size() > 0) ? colsQ[0] : '0;
      bus.img_empty_n  = (imgQ.size() > 0) && ($urandom_range(99) >= gapPct);
      bus.img_dout     = (imgQ.size() > 0) ? imgQ[0] : '0;
      case (readyMode)
         0:       bus.m_axis_tready = 1'b1;
         1:       bus.m_axis_tready = !bus.m_axis_tready;
         default: bus.m_axis_tready = 1'($urandom_range(1));
      endcase
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t vecs[7];
      int b0, i0, d0, r0, rr0, c0;

      vecs[0] = '{"basic2x3",  2, 3, 0, 0,  6};
      vecs[1] = '{"zeroRows",  0, 5, 0, 0,  0};
      vecs[2] = '{"toggle1x4", 1, 4, 1, 0,  4};
      vecs[3] = '{"zeroCols",  3, 0, 0, 0,  0};
      vecs[4] = '{"single1x1", 1, 1, 0, 0,  1};
      vecs[5] = '{"gappy3x2",  3, 2, 2, 40, 6};
      vecs[6] = '{"wide1x7",   1, 7, 1, 20, 7};

      rstN = 1'b0;
      bus.ap_start = 1'b0;
      bus.ap_continue = 1'b1;
      pixSeed = DATA_W'(1);
      repeat (3) @(posedge clk);
      #1 rstN = 1'b1;
      @(negedge clk);
      checkOutput("rstTvalid", 32'(bus.m_axis_tvalid), 32'd0);
      checkOutput("rstSideband", 32'({bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast}), 32'd0);
      checkOutput("rstDone", 32'(bus.ap_done), 32'd0);
      checkOutput("rstIdle", 32'(bus.ap_idle), 32'd1);
      checkOutput("rstReads", 32'({bus.rows_read, bus.cols_read, bus.img_read, bus.ap_ready}), 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         b0 = acceptCount; i0 = imgReadCount; d0 = doneCount;
         r0 = readyCount; rr0 = rowsReadCount; c0 = colsReadCount;
         readyMode = vecs[i].mode;
         gapPct = vecs[i].gap;
         applyStimulus(vecs[i].rows, vecs[i].cols);
         checkOutput({vecs[i].name, ".beats"}, 32'(acceptCount - b0), 32'(vecs[i].expBeats));
         checkOutput({vecs[i].name, ".imgReads"}, 32'(imgReadCount - i0), 32'(vecs[i].expBeats));
         checkOutput({vecs[i].name, ".doneCycles"}, 32'(doneCount - d0), 32'd1);
         checkOutput({vecs[i].name, ".readyCycles"}, 32'(readyCount - r0), 32'd1);
         checkOutput({vecs[i].name, ".dimPops"}, 32'({rowsReadCount - rr0, colsReadCount - c0}),
                     32'({32'd1, 32'd1}));
         checkOutput({vecs[i].name, ".leftover"}, 32'(expQ.size()), 32'd0);
         if (vecs[i].expBeats > 0)
            checkOutput({vecs[i].name, ".doneAfterLast"}, 32'(lastDoneCycle - lastAcceptCycle), 32'd1);
         else
            checkOutput({vecs[i].name, ".doneAfterDims"}, 32'(lastDoneCycle - lastReadyCycle), 32'd1);
         checkOutput({vecs[i].name, ".idleAfter"}, 32'(bus.ap_idle), 32'd1);
      end

      // Dimension pop must wait for both FIFOs.
      readyMode = 0; gapPct = 0;
      rr0 = rowsReadCount; c0 = colsReadCount; r0 = readyCount; d0 = doneCount;
      colsHold = 1'b1;
      pushFrame(1, 2);
      bus.ap_start = 1'b1;
      for (int k = 0; k < 10; k++) begin @(posedge clk); #1; end
      checkOutput("dimWait.reads", 32'(rowsReadCount - rr0 + colsReadCount - c0), 32'd0);
      checkOutput("dimWait.ready", 32'(readyCount - r0), 32'd0);
      colsHold = 1'b0;
      waitReady(r0 + 1);
      bus.ap_start = 1'b0;
      waitDone(d0 + 1);
      checkOutput("dimWait.rowsPops", 32'(rowsReadCount - rr0), 32'd1);
      checkOutput("dimWait.colsPops", 32'(colsReadCount - c0), 32'd1);
      checkOutput("dimWait.split", 32'(splitCount), 32'd0);

      // Back-to-back frames with ap_start held.
      @(posedge clk); #1;
      b0 = acceptCount; d0 = doneCount; r0 = readyCount;
      pushFrame(2, 2);
      pushFrame(1, 3);
      bus.ap_start = 1'b1;
      waitReady(r0 + 2);
      bus.ap_start = 1'b0;
      waitDone(d0 + 2);
      checkOutput("b2b.beats", 32'(acceptCount - b0), 32'd7);
      checkOutput("b2b.done", 32'(doneCount - d0), 32'd2);
      checkOutput("b2b.leftover", 32'(expQ.size() + imgQ.size()), 32'd0);

      // Done held until ap_continue.
      @(posedge clk); #1;
      bus.ap_continue = 1'b0;
      d0 = doneCount;
      pushFrame(1, 2);
      r0 = readyCount;
      bus.ap_start = 1'b1;
      waitReady(r0 + 1);
      bus.ap_start = 1'b0;
      waitDone(d0 + 1);
      for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
      checkOutput("doneHold.done", 32'(bus.ap_done), 32'd1);
      checkOutput("doneHold.idle", 32'(bus.ap_idle), 32'd0);
      bus.ap_continue = 1'b1;
      @(posedge clk); #1;
      checkOutput("doneHold.cleared", 32'(bus.ap_done), 32'd0);
      checkOutput("doneHold.idleBack", 32'(bus.ap_idle), 32'd1);

      // Reset in the middle of a frame, then a fresh 1x1 frame.
      b0 = acceptCount; r0 = readyCount; d0 = doneCount;
      pushFrame(2, 3);
      bus.ap_start = 1'b1;
      waitReady(r0 + 1);
      bus.ap_start = 1'b0;
      for (int k = 0; k < BUDGET && acceptCount < b0 + 3; k++) begin @(posedge clk); #1; end
      if (acceptCount < b0 + 3) checkOutput("midReset.timeout", 32'(acceptCount - b0), 32'd3);
      rstN = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      imgQ.delete();
      expQ.delete();
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("midReset.tvalid", 32'(bus.m_axis_tvalid), 32'd0);
      checkOutput("midReset.noDone", 32'(doneCount - d0), 32'd0);
      @(posedge clk); #1;
      b0 = acceptCount;
      pixSeed = DATA_W'(24'h00ABCD);
      applyStimulus(1, 1);
      checkOutput("midReset.newBeats", 32'(acceptCount - b0), 32'd1);

      // Randomized frames against the scoreboard.
      readyMode = 2; gapPct = 30;
      for (int i = 0; i < 12; i++) begin
         int rows, cols;
         rows = int'($urandom_range(4));
         cols = int'($urandom_range(5));
         pixSeed = DATA_W'($urandom);
         b0 = acceptCount; d0 = doneCount;
         applyStimulus(rows, cols);
         checkOutput("rand.beats", 32'(acceptCount - b0), 32'(rows * cols));
         checkOutput("rand.done", 32'(doneCount - d0), 32'd1);
         checkOutput("rand.leftover", 32'(expQ.size()), 32'd0);
      end
      checkOutput("final.split", 32'(splitCount), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
